// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display stages: hex glyph table and idle levels.
// Purely declarative; no timing or flow control.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; element i is the glyph for hex digit i.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // One registered set of pin levels for the display.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_out_t;

  localparam disp_out_t DISP_IDLE = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
// Zero latency; no flow control.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/disp_hex4.sv
// Four-digit multiplexed common-anode hex display driver with per-frame data latch.
// Outputs registered; each slot is TICK_DIV cycles; free-running, never stalls upstream.
module disp_hex4
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat,
  input  logic        blank_en,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  AN,
  output logic [6:0]  seg,
  output logic        seg_P,
  output logic        frame
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      dat_q, dat_d;
  logic             frame_q, frame_d;
  disp_out_t        out_q, out_d;

  logic       tick;
  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic [3:0] lead_zero;
  logic       blank_cur;

  assign tick = (cnt_q == TICK_LAST);
  assign nib  = dat_q[{idx_q, 2'b00} +: 4];

  // lead_zero[i]: every nibble from digit 3 down to digit i is zero; digit 0 never blanks.
  assign lead_zero[3] = (dat_q[15:12] == 4'h0);
  assign lead_zero[2] = lead_zero[3] && (dat_q[11:8] == 4'h0);
  assign lead_zero[1] = lead_zero[2] && (dat_q[7:4] == 4'h0);
  assign lead_zero[0] = 1'b0;
  assign blank_cur    = blank_en && lead_zero[idx_q];

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    dat_d   = (tick && (idx_q == 2'd3)) ? dat : dat_q;
    // Raised for the whole latch cycle, so frame and the dat_q load coincide.
    frame_d = (cnt_d == TICK_LAST) && (idx_d == 2'd3);
    out_d   = out_q;
    // Pins take the slot that is ending and hold it for a full slot, so AN, seg
    // and seg_P always switch on the same edge.
    if (tick) begin
      out_d.an  = ~(4'b0001 << idx_q);
      out_d.seg = blank_cur ? SEG_BLANK : hex_seg;
      out_d.dp  = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      dat_q   <= 16'h0000;
      frame_q <= 1'b0;
      out_q   <= DISP_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      frame_q <= frame_d;
      out_q   <= out_d;
    end
  end

  assign AN    = out_q.an;
  assign seg   = out_q.seg;
  assign seg_P = out_q.dp;
  assign frame = frame_q;

endmodule

// File: tb/tb_disp_hex4.sv
// Bench for disp_hex4 at TICK_DIV=4: directed scenarios plus randomized traffic against a cycle-count model.
module tb_disp_hex4;

  localparam int TD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] dat;
  logic        blank_en;
  logic [3:0]  dp_mask;
  logic [3:0]  AN;
  logic [6:0]  seg;
  logic        seg_P;
  logic        frame;

  int n_checks = 0;
  int n_fail   = 0;

  disp_hex4 #(.TICK_DIV(TD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .dat      (dat),
    .blank_en (blank_en),
    .dp_mask  (dp_mask),
    .AN       (AN),
    .seg      (seg),
    .seg_P    (seg_P),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] G_BLK = 7'b1111111;
  localparam logic [6:0] G_0   = 7'b1000000;
  localparam logic [6:0] G_1   = 7'b1111001;
  localparam logic [6:0] G_2   = 7'b0100100;
  localparam logic [6:0] G_5   = 7'b0010010;
  localparam logic [6:0] G_A   = 7'b0001000;
  localparam logic [6:0] G_D   = 7'b0100001;
  localparam logic [6:0] G_F   = 7'b0001110;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Digit s of word d; blank when it and every digit above it are zero.
  function automatic logic [6:0] digit_glyph(input logic [15:0] d, input int s, input logic be);
    logic [15:0] sh;
    sh = d >> (4 * s);
    if (be && s != 0 && sh == 16'h0) return 7'b1111111;
    return hex_glyph(sh[3:0]);
  endfunction

  // Edge k after reset release (k = 1, 2, ...): every 4th edge shows the slot just
  // finished; every 16th edge samples dat; frame is high after edges k % 16 == 15.
  function automatic int slot_of(input int k);
    return (k / TD - 1) % 4;
  endfunction

  int          m_n;
  logic [15:0] m_dat;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic        m_frame;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     <= 0;
      m_dat   <= 16'h0;
      m_an    <= 4'hF;
      m_seg   <= 7'h7F;
      m_dp    <= 1'b1;
      m_frame <= 1'b0;
    end else begin
      m_n <= m_n + 1;
      if ((m_n + 1) % TD == 0) begin
        m_an  <= ~(4'b0001 << slot_of(m_n + 1));
        m_seg <= digit_glyph(m_dat, slot_of(m_n + 1), blank_en);
        m_dp  <= ~dp_mask[slot_of(m_n + 1)];
      end
      if ((m_n + 1) % (4 * TD) == 0) m_dat <= dat;
      m_frame <= ((m_n + 1) % (4 * TD) == 4 * TD - 1);
    end
  end

  task automatic test_reset();
    int k;
    bit seen;
    rst = 1'b1; dat = 16'h0; blank_en = 1'b0; dp_mask = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({AN, seg, seg_P, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got AN=%b seg=%b P=%b frame=%b, want 1111 1111111 1 0", AN, seg, seg_P, frame);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (AN !== 4'hF) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || k != TD || AN !== 4'b1110) begin
      n_fail++;
      $display("FAIL first_anode: got AN=%b after %0d edges (seen=%0d), want 1110 after %0d", AN, k, seen, TD);
    end
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({AN, seg, seg_P, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got AN=%b seg=%b P=%b frame=%b, want 1111 1111111 1 0", AN, seg, seg_P, frame);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [6:0] want_seg [4];
    int w;
    want_seg[0] = G_F; want_seg[1] = G_A; want_seg[2] = G_2; want_seg[3] = G_1;
    dat = 16'h12AF; blank_en = 1'b0; dp_mask = 4'h0;
    for (w = 0; w < 80; w++) begin @(negedge clk); if (frame === 1'b1) break; end
    for (int j = 0; j < 20; j++) begin @(negedge clk); if (AN === 4'b1110) break; end
    n_checks++;
    if (w >= 80 || AN !== 4'b1110) begin
      n_fail++;
      $display("FAIL scan_start: frame wait=%0d AN=%b, want frame within 80 then AN=1110", w, AN);
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < TD; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        n_checks++;
        if (AN !== ~(4'b0001 << s) || seg !== want_seg[s] || seg_P !== 1'b1) begin
          n_fail++;
          $display("FAIL full_scan slot %0d cyc %0d: got AN=%b seg=%b P=%b, want AN=%b seg=%b P=1",
                   s, c, AN, seg, seg_P, ~(4'b0001 << s), want_seg[s]);
        end
      end
    end
  endtask

  logic [15:0] bl_dat [3]    = '{16'h0005, 16'h0000, 16'h0100};
  logic [6:0]  bl_exp [3][4] = '{'{G_5, G_BLK, G_BLK, G_BLK},
                                 '{G_0, G_BLK, G_BLK, G_BLK},
                                 '{G_0, G_0,   G_1,   G_BLK}};

  task automatic test_blanking();
    int d;
    for (int t = 0; t < 3; t++) begin
      dat = bl_dat[t]; blank_en = 1'b1; dp_mask = 4'h0;
      repeat (40) @(negedge clk);
      for (int c = 0; c < 4 * TD; c++) begin
        @(negedge clk);
        case (AN)
          4'b1110: d = 0;
          4'b1101: d = 1;
          4'b1011: d = 2;
          4'b0111: d = 3;
          default: d = -1;
        endcase
        n_checks++;
        if (d < 0 || seg !== bl_exp[t][d]) begin
          n_fail++;
          $display("FAIL blanking dat=%h: got AN=%b seg=%b, want one-hot-low AN with seg=%b",
                   bl_dat[t], AN, seg, (d < 0) ? 7'h00 : bl_exp[t][d]);
        end
      end
    end
  endtask

  task automatic test_no_tearing();
    int w;
    dat = 16'h1111; blank_en = 1'b0; dp_mask = 4'h0;
    repeat (40) @(negedge clk);
    for (w = 0; w < 20; w++) begin @(negedge clk); if (AN === 4'b1110) break; end
    dat = 16'h2222;
    for (w = 0; w < 20; w++) begin
      n_checks++;
      if (seg !== G_1) begin
        n_fail++;
        $display("FAIL tear_old_frame: got seg=%b AN=%b, want %b", seg, AN, G_1);
      end
      if (frame === 1'b1) break;
      @(negedge clk);
    end
    n_checks++;
    if (w >= 20) begin
      n_fail++;
      $display("FAIL tear_frame_pulse: got no frame within 20 cycles, want one");
    end
    for (int c = 0; c < 5 * TD; c++) begin
      @(negedge clk);
      n_checks++;
      if (c < TD ? (AN !== 4'b0111 || seg !== G_1) : (seg !== G_2 || AN === 4'hF)) begin
        n_fail++;
        $display("FAIL tear_new_frame cyc %0d: got AN=%b seg=%b, want %s", c, AN, seg,
                 (c < TD) ? "AN=0111 seg=1111001" : "seg=0100100");
      end
    end
  endtask

  task automatic test_decimal_point();
    dat = 16'h0005; blank_en = 1'b1; dp_mask = 4'b0100;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 4 * TD; c++) begin
      @(negedge clk);
      n_checks++;
      if (seg_P !== (AN !== 4'b1011) || (AN === 4'b1011 && seg !== G_BLK)) begin
        n_fail++;
        $display("FAIL decimal_point: got AN=%b seg=%b P=%b, want P=%b and blank digit 2",
                 AN, seg, seg_P, (AN !== 4'b1011));
      end
    end
    dp_mask = 4'h0;
  endtask

  task automatic test_reset_at_latch();
    int w;
    dat = 16'h5555; blank_en = 1'b0; dp_mask = 4'h0;
    repeat (40) @(negedge clk);
    for (w = 0; w < 20; w++) begin @(negedge clk); if (frame === 1'b1) break; end
    dat = 16'hABCD;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < 5 * TD; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg !== ((AN === 4'hF) ? G_BLK : G_0)) begin
        n_fail++;
        $display("FAIL latch_reset edge %0d: got AN=%b seg=%b, want cleared data (zeros)", k, AN, seg);
      end
    end
    @(negedge clk);
    n_checks++;
    if (w >= 20 || AN !== 4'b1110 || seg !== G_D) begin
      n_fail++;
      $display("FAIL latch_reset_next_frame: got AN=%b seg=%b (wait=%0d), want AN=1110 seg=%b", AN, seg, w, G_D);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      n_checks++;
      if ({AN, seg, seg_P, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got AN=%b seg=%b P=%b frame=%b, want AN=%b seg=%b P=%b frame=%b",
                 c, AN, seg, seg_P, frame, m_an, m_seg, m_dp, m_frame);
      end
      if (rst) rst = 1'b0;
      r = $urandom;
      if ($urandom_range(7) == 0) dat = r[15:0] >> (4 * $urandom_range(3));
      if ($urandom_range(15) == 0) blank_en = ~blank_en;
      if ($urandom_range(11) == 0) dp_mask = r[19:16];
      if ($urandom_range(249) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dat = 16'h0; blank_en = 1'b0; dp_mask = 4'h0;
    test_reset();
    test_full_scan();
    test_blanking();
    test_no_tearing();
    test_decimal_point();
    test_reset_at_latch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
